branch_history_predictor: RTL

Fetch-side counterpart of the execute-stage branch comparator. It predicts a conditional branch's direction at fetch time. It then learns from the resolved taken/not-taken result that the comparator produces for the same branch in execute. The block holds a direct-mapped table of 2-bit saturating counters, flags mispredictions for the pipeline flush logic, and counts them for performance monitoring.

---
 rtl/branch_history_predictor_pkg.sv | 32 +++
 rtl/branch_history_predictor_if.sv | 41 ++++
 rtl/branch_history_predictor_sat_counter2.sv | 33 +++
 rtl/branch_history_predictor.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/branch_history_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_predictor_pkg
// Description : Shared definitions for the fetch-side branch predictor.
//               - 2-bit saturating counter encodings
//               - predictor FSM state encoding
//               - branch funct3 codes used by the execute-side glue that
//                 drives the predictor update port
// Revision    : 1.0 - initial release
// ============================================================================
package branch_history_predictor_pkg;

    // 2-bit direction counter encodings; bit 1 is the predicted direction
    localparam logic [1:0] C_SNT = 2'b00;   // strong not-taken
    localparam logic [1:0] C_WNT = 2'b01;   // weak not-taken (clear value)
    localparam logic [1:0] C_WT  = 2'b10;   // weak taken
    localparam logic [1:0] C_ST  = 2'b11;   // strong taken

    // Predictor FSM states
    localparam logic [0:0] C_FSM_INIT = 1'b0;
    localparam logic [0:0] C_FSM_RUN  = 1'b1;

    // Branch funct3 codes shared with the execute-stage comparator
    localparam logic [2:0] C_F_BEQ  = 3'b000;
    localparam logic [2:0] C_F_BNE  = 3'b001;
    localparam logic [2:0] C_F_BLT  = 3'b100;
    localparam logic [2:0] C_F_BGE  = 3'b101;
    localparam logic [2:0] C_F_BLTU = 3'b110;
    localparam logic [2:0] C_F_BGEU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/branch_history_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_predictor_if
// Description : Lookup / update / status bundle between the pipeline and the
//               branch predictor.
//               master : pipeline side (drives lkp_*, upd_*)
//               slave  : predictor side (drives init_done, pred_*,
//                        mispredict, mispredict_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_history_predictor_if
    import branch_history_predictor_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);

    logic             init_done;
    logic             lkp_valid;
    logic [XLEN-1:0]  lkp_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic             upd_pred;
    logic             mispredict;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken, upd_pred,
        input  init_done, pred_valid, pred_taken, mispredict, mispredict_cnt
    );

    modport slave (
        input  lkp_valid, lkp_pc, upd_valid, upd_pc, upd_taken, upd_pred,
        output init_done, pred_valid, pred_taken, mispredict, mispredict_cnt
    );

endinterface
`default_nettype wire

// File: rtl/branch_history_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : Next-value logic of a 2-bit saturating direction counter.
//               Ports:
//                 i_cnt   - current counter value
//                 i_taken - resolved outcome (1 = increment, 0 = decrement)
//                 o_cnt   - next counter value, saturating at 00 / 11
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
    import branch_history_predictor_pkg::*;
(
    input  wire logic [1:0] i_cnt,
    input  wire logic       i_taken,
    output logic      [1:0] o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_taken) begin
            if (i_cnt != C_ST) begin
                o_cnt = i_cnt + 2'd1;
            end
        end else begin
            if (i_cnt != C_SNT) begin
                o_cnt = i_cnt - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_history_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_history_predictor
// Description : Direct-mapped table of 2-bit saturating counters predicting
//               conditional branch direction at fetch and trained by the
//               execute-stage resolution. After reset an INIT phase writes
//               the weak-not-taken value into every entry, one per cycle.
//               Ports:
//                 clk - clock, all state changes on rising edge
//                 rst - synchronous active-high reset
//                 bp  - slave side of branch_history_predictor_if
//                       (lookup, update, prediction, mispredict status)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_history_predictor
    import branch_history_predictor_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int IDX_W = 6,
    parameter int CNT_W = 32
)(
    input wire logic                  clk,
    input wire logic                  rst,
    branch_history_predictor_if.slave bp
);

    localparam int               C_DEPTH    = 2**IDX_W;
    localparam logic [IDX_W-1:0] C_LAST_IDX = '1;

    logic [1:0]       r_table [C_DEPTH];
    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] r_init_idx;

    logic             r_pred_valid;
    logic             r_pred_taken;
    logic             r_mispredict;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic [IDX_W-1:0] w_lkp_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_run;
    logic             w_lkp_acc;
    logic             w_upd_acc;
    logic             w_miss;
    logic [1:0]       w_upd_cnt;

    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [1:0]       w_wr_data;

    // Word-aligned PCs: drop pc[1:0]; no tag, so higher bits alias freely
    assign w_lkp_idx = bp.lkp_pc[IDX_W+1:2];
    assign w_upd_idx = bp.upd_pc[IDX_W+1:2];

    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{bp.lkp_pc[XLEN-1:IDX_W+2], bp.lkp_pc[1:0],
                                bp.upd_pc[XLEN-1:IDX_W+2], bp.upd_pc[1:0]};

    assign w_run     = (r_state == C_FSM_RUN);
    assign w_lkp_acc = w_run & bp.lkp_valid;
    assign w_upd_acc = w_run & bp.upd_valid;
    assign w_miss    = w_upd_acc & (bp.upd_taken ^ bp.upd_pred);

    sat_counter2 u_sat_counter2 (
        .i_cnt   (r_table[w_upd_idx]),
        .i_taken (bp.upd_taken),
        .o_cnt   (w_upd_cnt)
    );

    // Next state and the single table write port (INIT clear or RUN update)
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_init_idx;
        w_wr_data   = C_WNT;
        case (r_state)
            C_FSM_INIT: begin
                w_wr_en = 1'b1;
                if (r_init_idx == C_LAST_IDX) begin
                    w_state_nxt = C_FSM_RUN;
                end
            end
            C_FSM_RUN: begin
                if (w_upd_acc) begin
                    w_wr_en   = 1'b1;
                    w_wr_idx  = w_upd_idx;
                    w_wr_data = w_upd_cnt;
                end
            end
            default: begin
                w_state_nxt = C_FSM_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= C_FSM_INIT;
            r_init_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_run) begin
                r_init_idx <= r_init_idx + 1'b1;
            end
        end
    end

    // Table contents are not reset; the INIT walk establishes them
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_table[w_wr_idx] <= w_wr_data;
        end
    end

    // Lookup reads the pre-write counter, giving read-before-write on a
    // same-index lookup/update collision
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_valid     <= 1'b0;
            r_pred_taken     <= 1'b0;
            r_mispredict     <= 1'b0;
            r_mispredict_cnt <= '0;
        end else begin
            r_pred_valid <= w_lkp_acc;
            if (w_lkp_acc) begin
                r_pred_taken <= r_table[w_lkp_idx][1];
            end
            r_mispredict <= w_miss;
            if (w_miss && (r_mispredict_cnt != {CNT_W{1'b1}})) begin
                r_mispredict_cnt <= r_mispredict_cnt + 1'b1;
            end
        end
    end

    assign bp.init_done      = w_run;
    assign bp.pred_valid     = r_pred_valid;
    assign bp.pred_taken     = r_pred_taken;
    assign bp.mispredict     = r_mispredict;
    assign bp.mispredict_cnt = r_mispredict_cnt;

endmodule
`default_nettype wire
